// File: rtl/hps_nn_pkg.sv
// ----------------------------------------------------------------------------
// hps_nn_pkg
//
// Purpose:
//   Shared definitions for the HPS clock/reset conditioner: controller state
//   encoding, Avalon register map, status word bit positions and counter
//   widths, plus a helper that packs the status word.
//
// Contents:
//   nn_state_e      RESET_HOLD / IDLE / BURST controller states
//   ADDR_*          read-only register addresses
//   STAT_*          bit positions inside the status word
//   HOLD_CNT_W      width of the reset-hold counter
//   BURST_CNT_W     width of the burst pulse counter
//   statusWord()    packs {overrun, busy, nn_reset_n} into a 32-bit word
// ----------------------------------------------------------------------------
package hps_nn_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    IDLE       = 2'd1,
    BURST      = 2'd2
  } nn_state_e;

  localparam logic [1:0] ADDR_STEP_CNT = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_HOLD_CFG = 2'd2;

  localparam int STAT_NN_RESET_N = 0;
  localparam int STAT_BUSY       = 1;
  localparam int STAT_OVERRUN    = 2;

  localparam int HOLD_CNT_W  = 16;
  localparam int BURST_CNT_W = 8;

  // Status word layout; every bit not named by a STAT_* index reads zero.
  function automatic logic [31:0] statusWord(input logic overrun,
                                             input logic busy,
                                             input logic nnResetN);
    logic [31:0] word;
    word                  = '0;
    word[STAT_OVERRUN]    = overrun;
    word[STAT_BUSY]       = busy;
    word[STAT_NN_RESET_N] = nnResetN;
    return word;
  endfunction

endpackage

// File: rtl/hps_sync_edge.sv
// ----------------------------------------------------------------------------
// hps_sync_edge
//
// Purpose:
//   Brings one slow, software-driven level into the clk domain through a
//   STAGES-deep flop chain and flags its rising edge. The edge flag is high
//   for exactly one cycle, in the cycle the synchronized level first reads 1.
//
// Parameters:
//   STAGES      synchronizer depth (2..4)
//
// Ports:
//   clk_i       system clock
//   reset_n_i   asynchronous active-low reset; clears chain and edge history
//   d_i         asynchronous input level
//   level_o     synchronized level (last chain stage)
//   rise_o      one-cycle rising-edge flag of level_o
// ----------------------------------------------------------------------------
module hps_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw level through the chain and keep the previous synchronized
  // value one flop behind, so the edge compare only ever sees settled data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hps_clock_reset_conditioner.sv
// ----------------------------------------------------------------------------
// hps_clock_reset_conditioner
//
// Purpose:
//   Converts the HPS PIO's software step level (ctrl_in[0]) and software
//   reset level (ctrl_in[1]) into a single-cycle datapath clock enable per
//   step and a stretched active-low datapath reset. A read-only Avalon-MM
//   slave exposes the step count, status flags and the hold configuration.
//
// Build option:
//   HPS_CLKRST_STEP_BURST_EN  when defined, each step edge emits BURST_LEN
//                             back-to-back enables and a step edge seen
//                             mid-burst sets a sticky overrun flag. When
//                             undefined, one enable per edge, overrun reads 0.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth on ctrl_in (2..4)
//   RST_HOLD_CYCLES  cycles nn_reset_n stays low after reset release
//   BURST_LEN        enables per step edge in burst builds (1..255)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   ctrl_in     [0] step level, [1] soft reset level (1 = assert)
//   address     Avalon read address
//   chipselect  Avalon select; readdata is valid while high
//   readdata    Avalon read data, combinational from address
//   nn_clk_en   registered one-cycle enable pulse to the datapath
//   nn_reset_n  registered active-low datapath reset
//   busy        high while in RESET_HOLD or BURST
// ----------------------------------------------------------------------------
module hps_clock_reset_conditioner
  import hps_nn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int BURST_LEN       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ctrl_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        nn_clk_en,
  output logic        nn_reset_n,
  output logic        busy
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = HOLD_CNT_W'(RST_HOLD_CYCLES);

  nn_state_e             state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic [31:0]           stepCount_q, stepCount_d;
  logic                  clkEn_q, clkEn_d;
  logic                  nnResetN_q, nnResetN_d;
  logic                  overrunFlag;

  logic                  stepLevel, stepRise;
  logic                  softLevel, softRise;
  logic                  unusedSyncOutputs;

  hps_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .d_i       (ctrl_in[0]),
    .level_o   (stepLevel),
    .rise_o    (stepRise)
  );

  hps_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_soft_sync (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .d_i       (ctrl_in[1]),
    .level_o   (softLevel),
    .rise_o    (softRise)
  );

  // Only the step edge and the soft reset level drive the controller.
  assign unusedSyncOutputs = stepLevel ^ softRise;

`ifdef HPS_CLKRST_STEP_BURST_EN
  localparam logic [BURST_CNT_W-1:0] BURST_REMAIN = BURST_CNT_W'(BURST_LEN - 1);

  logic                   overrun_q, overrun_d;
  logic [BURST_CNT_W-1:0] burstLeft_q, burstLeft_d;

  assign overrunFlag = overrun_q;

  // Next-state logic. RESET_HOLD ignores steps entirely; in any other state
  // the soft reset level has priority over a coincident step edge, so a
  // burst in flight is abandoned on the spot and no enable is emitted.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stepCount_d = stepCount_q;
    clkEn_d     = 1'b0;
    nnResetN_d  = nnResetN_q;
    overrun_d   = overrun_q;
    burstLeft_d = burstLeft_q;
    if (state_q == RESET_HOLD) begin
      nnResetN_d = 1'b0;
      if (softLevel) begin
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q - HOLD_CNT_W'(1);
        if (hold_d == '0) begin
          state_d    = IDLE;
          nnResetN_d = 1'b1;
        end
      end
    end else if (softLevel) begin
      state_d     = RESET_HOLD;
      hold_d      = HOLD_RELOAD;
      stepCount_d = '0;
      overrun_d   = 1'b0;
      nnResetN_d  = 1'b0;
      burstLeft_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stepRise) begin
            clkEn_d     = 1'b1;
            stepCount_d = stepCount_q + 32'd1;
            burstLeft_d = BURST_REMAIN;
            if (BURST_LEN > 1) begin
              state_d = BURST;
            end
          end
        end
        BURST: begin
          clkEn_d     = 1'b1;
          stepCount_d = stepCount_q + 32'd1;
          burstLeft_d = burstLeft_q - BURST_CNT_W'(1);
          if (stepRise) begin
            overrun_d = 1'b1;
          end
          if (burstLeft_q == BURST_CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = RESET_HOLD;
          hold_d     = HOLD_RELOAD;
          nnResetN_d = 1'b0;
        end
      endcase
    end
  end

  // Burst bookkeeping registers, cleared with the rest of the controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q   <= 1'b0;
      burstLeft_q <= '0;
    end else begin
      overrun_q   <= overrun_d;
      burstLeft_q <= burstLeft_d;
    end
  end
`else
  logic [7:0] unusedBurstLen;

  // BURST_LEN has no role when every step edge yields a single enable.
  assign unusedBurstLen = 8'(BURST_LEN);
  assign overrunFlag    = 1'b0;

  // Next-state logic. RESET_HOLD ignores steps entirely; from IDLE the soft
  // reset level has priority over a coincident step edge, so that step is
  // neither pulsed nor counted.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stepCount_d = stepCount_q;
    clkEn_d     = 1'b0;
    nnResetN_d  = nnResetN_q;
    if (state_q == RESET_HOLD) begin
      nnResetN_d = 1'b0;
      if (softLevel) begin
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q - HOLD_CNT_W'(1);
        if (hold_d == '0) begin
          state_d    = IDLE;
          nnResetN_d = 1'b1;
        end
      end
    end else if (softLevel) begin
      state_d     = RESET_HOLD;
      hold_d      = HOLD_RELOAD;
      stepCount_d = '0;
      nnResetN_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (stepRise) begin
        clkEn_d     = 1'b1;
        stepCount_d = stepCount_q + 32'd1;
      end
    end else begin
      state_d    = RESET_HOLD;
      hold_d     = HOLD_RELOAD;
      nnResetN_d = 1'b0;
    end
  end
`endif

  // Controller state and the registered datapath controls. Hard reset parks
  // the machine in RESET_HOLD with a full hold count so the datapath reset
  // is stretched after power-on exactly as after a soft reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_HOLD;
      hold_q      <= HOLD_RELOAD;
      stepCount_q <= '0;
      clkEn_q     <= 1'b0;
      nnResetN_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stepCount_q <= stepCount_d;
      clkEn_q     <= clkEn_d;
      nnResetN_q  <= nnResetN_d;
    end
  end

  assign nn_clk_en  = clkEn_q;
  assign nn_reset_n = nnResetN_q;
  assign busy       = (state_q != IDLE);

  // Unregistered read mux with no side effects; the bus reads zero whenever
  // the slave is not selected.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_STEP_CNT: readdata = stepCount_q;
        ADDR_STATUS:   readdata = statusWord(overrunFlag, busy, nnResetN_q);
        ADDR_HOLD_CFG: readdata = 32'(RST_HOLD_CYCLES);
        default:       readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hps_clock_reset_conditioner.sv
// ----------------------------------------------------------------------------
// tb_hps_clock_reset_conditioner
//
// Directed bench for hps_clock_reset_conditioner. A reference model derives
// the expected outputs from the input history: the controller sees each input
// SYNC_STAGES edges after it was sampled, the datapath reset releases after
// RST_HOLD_CYCLES consecutive quiet edges, and each step edge yields PULSES
// enables. A negedge process compares every output against that model, and
// the directed sequence adds literal expectations for timing and readback.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hps_clock_reset_conditioner;

  localparam int SYNC_STAGES     = 2;
  localparam int RST_HOLD_CYCLES = 16;
  localparam int BURST_LEN       = 4;
  localparam int DEPTH           = 4096;
`ifdef HPS_CLKRST_STEP_BURST_EN
  localparam int PULSES = BURST_LEN;
`else
  localparam int PULSES = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  ctrl_in;
  logic [1:0]  address;
  logic        chipselect;
  logic [31:0] readdata;
  logic        nn_clk_en;
  logic        nn_reset_n;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;
  int pulseCount  = 0;
  bit checkEnable = 1'b0;
  bit preloadReq  = 1'b0;

  hps_clock_reset_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
    .BURST_LEN       (BURST_LEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctrl_in    (ctrl_in),
    .address    (address),
    .chipselect (chipselect),
    .readdata   (readdata),
    .nn_clk_en  (nn_clk_en),
    .nn_reset_n (nn_reset_n),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: input history indexed by edge number since reset
  // release, plus the abstract controller condition derived from it.
  logic        stepAt [0:DEPTH-1];
  logic        softAt [0:DEPTH-1];
  int          edgeIdx;
  bit          mInHold;
  int          mQuiet;
  logic [31:0] mCount;
  bit          mOverrun;
  bit          mPulse;
  int          mBurstLeft;
  logic        softSeen;
  logic        riseSeen;
  logic        mBusy;
  logic [31:0] mReaddata;

  // What the controller sees at the current edge: the inputs sampled
  // SYNC_STAGES edges earlier; anything before reset release counts as 0.
  always_comb begin
    softSeen = 1'b0;
    riseSeen = 1'b0;
    if (edgeIdx >= SYNC_STAGES && edgeIdx < DEPTH) begin
      softSeen = softAt[edgeIdx-SYNC_STAGES];
      if (edgeIdx == SYNC_STAGES) begin
        riseSeen = stepAt[edgeIdx-SYNC_STAGES];
      end else begin
        riseSeen = stepAt[edgeIdx-SYNC_STAGES] & ~stepAt[edgeIdx-SYNC_STAGES-1];
      end
    end
  end

  // Model update per clock edge: reset hold counts quiet edges, a seen soft
  // reset clears everything, a pending burst keeps pulsing, a new edge pulses.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgeIdx    <= 0;
      mInHold    <= 1'b1;
      mQuiet     <= 0;
      mCount     <= '0;
      mOverrun   <= 1'b0;
      mPulse     <= 1'b0;
      mBurstLeft <= 0;
    end else begin
      edgeIdx <= edgeIdx + 1;
      if (edgeIdx < DEPTH) begin
        stepAt[edgeIdx] <= ctrl_in[0];
        softAt[edgeIdx] <= ctrl_in[1];
      end
      mPulse <= 1'b0;
      if (preloadReq) begin
        mCount <= 32'hFFFF_FFFF;
      end else if (mInHold) begin
        if (softSeen) begin
          mQuiet <= 0;
        end else if (mQuiet + 1 == RST_HOLD_CYCLES) begin
          mInHold <= 1'b0;
          mQuiet  <= 0;
        end else begin
          mQuiet <= mQuiet + 1;
        end
      end else if (softSeen) begin
        mInHold    <= 1'b1;
        mQuiet     <= 0;
        mCount     <= '0;
        mOverrun   <= 1'b0;
        mBurstLeft <= 0;
      end else if (mBurstLeft > 0) begin
        mPulse     <= 1'b1;
        mCount     <= mCount + 32'd1;
        mBurstLeft <= mBurstLeft - 1;
        if (riseSeen) begin
          mOverrun <= 1'b1;
        end
      end else if (riseSeen) begin
        mPulse     <= 1'b1;
        mCount     <= mCount + 32'd1;
        mBurstLeft <= PULSES - 1;
      end
    end
  end

  // Expected bus view of the model.
  always_comb begin
    mBusy     = mInHold || (mBurstLeft != 0);
    mReaddata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    mReaddata = mCount;
        2'd1:    mReaddata = {29'b0, mOverrun, mBusy, ~mInHold};
        2'd2:    mReaddata = 32'(RST_HOLD_CYCLES);
        default: mReaddata = '0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEnable) begin
      if (nn_clk_en === 1'b1) begin
        pulseCount++;
      end
      checkOutput("cycle nn_clk_en", {31'b0, nn_clk_en}, {31'b0, mPulse});
      checkOutput("cycle nn_reset_n", {31'b0, nn_reset_n}, {31'b0, ~mInHold});
      checkOutput("cycle busy", {31'b0, busy}, {31'b0, mBusy});
      checkOutput("cycle readdata", readdata, mReaddata);
    end
  end

  // All directed actions happen 3 time units after a rising edge.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ctrl);
    ctrl_in = ctrl;
  endtask

  task automatic readReg(input logic [1:0] addr, input string name,
                         input logic [31:0] expected);
    address = addr;
    #1;
    checkOutput(name, readdata, expected);
  endtask

  // Edges until a DUT output reaches a level, bounded by a cycle budget.
  task automatic edgesUntil(input bit useReset, input logic level, input int limit,
                            output int n);
    n = 0;
    while (n < limit) begin
      waitCycles(1);
      if ((useReset ? nn_reset_n : nn_clk_en) === level) break;
      n++;
    end
  endtask

  task automatic stepOnce();
    applyStimulus(2'b01);
    waitCycles(20);
    applyStimulus(2'b00);
    waitCycles(20);
  endtask

  task automatic waitRelease(input string name);
    int n;
    edgesUntil(1'b1, 1'b1, 60, n);
    checkOutput(name, {31'b0, nn_reset_n}, 32'd1);
  endtask

  initial begin
    int n;
    int p0;
    reset_n    = 1'b1;
    ctrl_in    = 2'b00;
    address    = 2'd1;
    chipselect = 1'b1;
    #1 reset_n = 1'b0;
    #1 checkEnable = 1'b1;
    waitCycles(3);

    checkOutput("reset nn_reset_n", {31'b0, nn_reset_n}, 32'd0);
    checkOutput("reset nn_clk_en", {31'b0, nn_clk_en}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd1);
    readReg(2'd1, "reset status", 32'h2);
    readReg(2'd0, "reset count", 32'h0);

    reset_n = 1'b1;
    n = 0;
    while (n < 100) begin
      waitCycles(1);
      n++;
      if (nn_reset_n === 1'b1) break;
    end
    checkOutput("poweron hold edges", n, 32'd16);
    checkOutput("poweron busy", {31'b0, busy}, 32'd0);
    readReg(2'd1, "poweron status", 32'h1);
    readReg(2'd2, "hold cfg", 32'd16);
    readReg(2'd3, "addr3", 32'd0);
    chipselect = 1'b0;
    readReg(2'd2, "chipselect low", 32'd0);
    chipselect = 1'b1;

    p0 = pulseCount;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01);
      edgesUntil(1'b0, 1'b1, 10, n);
      checkOutput("step latency", n, 32'd2);
`ifndef HPS_CLKRST_STEP_BURST_EN
      waitCycles(1);
      checkOutput("step single cycle", {31'b0, nn_clk_en}, 32'd0);
      waitCycles(17);
`else
      waitCycles(18);
`endif
      applyStimulus(2'b00);
      waitCycles(20);
    end
    checkOutput("three step pulses", pulseCount - p0, 32'(3 * PULSES));
    readReg(2'd0, "three step count", 32'(3 * PULSES));

    applyStimulus(2'b10);
    edgesUntil(1'b1, 1'b0, 10, n);
    checkOutput("soft reset latency", n, 32'd2);
    waitCycles(2);
    applyStimulus(2'b00);
    n = 3;
    while (n < 60) begin
      waitCycles(1);
      if (nn_reset_n === 1'b1) break;
      n++;
    end
    checkOutput("soft reset low edges", n, 32'd20);
    readReg(2'd0, "count after soft reset", 32'd0);

    stepOnce();
    readReg(2'd0, "count before collision", 32'(PULSES));
    p0 = pulseCount;
    applyStimulus(2'b11);
    waitCycles(5);
    checkOutput("collision pulses", pulseCount - p0, 32'd0);
    checkOutput("collision nn_reset_n", {31'b0, nn_reset_n}, 32'd0);
    checkOutput("collision busy", {31'b0, busy}, 32'd1);
    readReg(2'd0, "collision count", 32'd0);
    applyStimulus(2'b00);
    waitRelease("collision release");
    waitCycles(5);

    @(negedge clk);
    #1;
    force dut.stepCount_q = 32'hFFFF_FFFF;
    preloadReq = 1'b1;
    @(posedge clk);
    #1;
    release dut.stepCount_q;
    preloadReq = 1'b0;
    #2;
    readReg(2'd0, "preloaded count", 32'hFFFF_FFFF);
    stepOnce();
    readReg(2'd0, "wrapped count", 32'(PULSES - 1));

`ifdef HPS_CLKRST_STEP_BURST_EN
    p0 = pulseCount;
    stepOnce();
    checkOutput("burst pulses", pulseCount - p0, 32'(BURST_LEN));

    p0 = pulseCount;
    applyStimulus(2'b01);
    waitCycles(1);
    applyStimulus(2'b00);
    waitCycles(1);
    applyStimulus(2'b01);
    waitCycles(12);
    checkOutput("overrun pulses", pulseCount - p0, 32'(BURST_LEN));
    readReg(2'd1, "overrun status", 32'h5);
    applyStimulus(2'b00);
    waitCycles(20);

    p0 = pulseCount;
    applyStimulus(2'b01);
    waitCycles(2);
    applyStimulus(2'b11);
    waitCycles(8);
    checkOutput("aborted burst pulses", pulseCount - p0, 32'd2);
    readReg(2'd1, "aborted status", 32'h2);
    applyStimulus(2'b00);
    waitRelease("abort release");
    waitCycles(5);
`endif

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
